// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the dual-clock FIFO write port among NUM_REQ write-domain requesters.
// Optional per-requester beat and stall statistics are enabled with `define FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BITS      = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                       wr_clk,
  input  logic                       wr_rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*BITS-1:0]    req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       wr_en,
  output logic [BITS-1:0]            wr_data,
  input  logic                       wr_full,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]      beat_count,
  output logic [15:0]                stall_count
`endif
);

  localparam int unsigned OW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t          state;
  logic [OW-1:0]   rr_last;
  logic [OW-1:0]   winner;
  logic [CW-1:0]   beat_cnt;
  logic            any_req;
  logic            sel_req;
  logic            sel_last;
  logic [BITS-1:0] sel_data;
  logic            last_beat;

  // Round-robin search: lowest index above rr_last wins, otherwise wrap to the lowest index overall.
  always_comb begin
    winner  = rr_last;
    any_req = 1'b0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req[i] && (OW'(i) <= rr_last)) begin
        winner  = OW'(i);
        any_req = 1'b1;
      end
    end
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req[i] && (OW'(i) > rr_last)) begin
        winner  = OW'(i);
        any_req = 1'b1;
      end
    end
  end

  // Owner's request, last flag and data.
  always_comb begin
    sel_req  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (OW'(i) == owner) begin
        sel_req  = req[i];
        sel_last = req_last[i];
        sel_data = req_data[i*BITS +: BITS];
      end
    end
  end

  // FIFO write port is driven straight from the held grant so a beat costs no extra cycle.
  always_comb begin
    busy      = (state == BURST);
    wr_en     = busy && sel_req && !wr_full;
    wr_data   = wr_en ? sel_data : '0;
    ack       = wr_en ? (NUM_REQ'(1) << owner) : '0;
    last_beat = wr_en && (sel_last || (beat_cnt == CW'(MAX_BURST - 1)));
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      rr_last  <= OW'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= winner;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (last_beat) begin
            state    <= IDLE;
            rr_last  <= owner;
            beat_cnt <= '0;
          end else if (wr_en) begin
            beat_cnt <= CW'(beat_cnt + 1'b1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  // Saturating per-requester accepted-beat counters and a shared full-stall counter.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      beat_count  <= '0;
      stall_count <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (ack[i] && (beat_count[i*16 +: 16] != 16'hFFFF)) begin
          beat_count[i*16 +: 16] <= beat_count[i*16 +: 16] + 16'd1;
        end
      end
      if (busy && sel_req && wr_full && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter; requesters are modelled as beat queues popped on ack.
// Also checks the statistics outputs when FIFO_WR_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned BITS      = 32;
  localparam int unsigned MAX_BURST = 8;

  logic                    wr_clk = 1'b0;
  logic                    wr_rst_n;
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*BITS-1:0] req_data;
  logic [NUM_REQ-1:0]      req_last;
  logic [NUM_REQ-1:0]      ack;
  logic                    wr_en;
  logic [BITS-1:0]         wr_data;
  logic                    wr_full;
  logic                    busy;
  logic [1:0]              owner;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]   beat_count;
  logic [15:0]             stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q_data [NUM_REQ][$];
  logic        q_last [NUM_REQ][$];
  logic [31:0] wr_log [$];

  logic              o_wr_en;
  logic [NUM_REQ-1:0] o_ack;
  logic [BITS-1:0]   o_data;
  logic              o_busy;
  logic [1:0]        o_owner;

  fifo_wr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .BITS     (BITS),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .wr_clk     (wr_clk),
    .wr_rst_n   (wr_rst_n),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .ack        (ack),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_full    (wr_full),
    .busy       (busy),
    .owner      (owner)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .beat_count (beat_count),
    .stall_count(stall_count)
`endif
  );

  always #5 wr_clk = ~wr_clk;

  task automatic load(input int i, input logic [31:0] d, input logic l);
    q_data[i].push_back(d);
    q_last[i].push_back(l);
  endtask

  task automatic clear_all();
    for (int i = 0; i < NUM_REQ; i++) begin
      q_data[i].delete();
      q_last[i].delete();
    end
    wr_log.delete();
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (q_data[i].size() > 0) begin
        req[i] = 1'b1;
        req_data[i*BITS +: BITS] = q_data[i][0];
        req_last[i] = q_last[i][0];
      end else begin
        req[i] = 1'b0;
        req_data[i*BITS +: BITS] = '0;
        req_last[i] = 1'b0;
      end
    end
  endtask

  // One clock: present requester heads, sample at negedge, pop acked heads after the edge.
  task automatic cycle();
    drive_reqs();
    @(negedge wr_clk);
    o_wr_en = wr_en;
    o_ack   = ack;
    o_data  = wr_data;
    o_busy  = busy;
    o_owner = owner;
    if (wr_en) wr_log.push_back(wr_data);
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (o_ack[i] && q_data[i].size() > 0) begin
        void'(q_data[i].pop_front());
        void'(q_last[i].pop_front());
      end
    end
  endtask

  task automatic do_reset();
    wr_rst_n = 1'b0;
    wr_full  = 1'b0;
    clear_all();
    drive_reqs();
    @(posedge wr_clk);
    @(posedge wr_clk);
    #1;
    wr_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    wr_rst_n = 1'b0;
    wr_full  = 1'b0;
    clear_all();
    for (int i = 0; i < NUM_REQ; i++) load(i, 32'hAA00 + i, 1'b1);
    drive_reqs();
    #12;
    @(posedge wr_clk);
    #2;
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
    n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", ack); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d expected 0", owner); end
    n_checks++; if (wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
`ifdef FIFO_WR_ARB_STATS_EN
    n_checks++; if (beat_count !== '0 || stall_count !== 16'h0) begin n_fail++; $display("FAIL reset_stats: got %h/%h expected 0/0", beat_count, stall_count); end
`endif
  endtask

  task automatic test_single();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'hA1A1_0001;
    exp_d[1] = 32'hA2A2_0002;
    exp_d[2] = 32'hA3A3_0003;
    do_reset();
    for (int k = 0; k < 3; k++) load(0, exp_d[k], (k == 2));
    cycle();
    n_checks++; if (o_busy !== 1'b0 || o_wr_en !== 1'b0) begin n_fail++; $display("FAIL single_arb: got busy=%b wr_en=%b expected 0/0", o_busy, o_wr_en); end
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_checks++; if (o_wr_en !== 1'b1 || o_busy !== 1'b1) begin n_fail++; $display("FAIL single_en[%0d]: got wr_en=%b busy=%b expected 1/1", k, o_wr_en, o_busy); end
      n_checks++; if (o_ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack[%0d]: got %b expected 0001", k, o_ack); end
      n_checks++; if (o_data !== exp_d[k]) begin n_fail++; $display("FAIL single_data[%0d]: got %h expected %h", k, o_data, exp_d[k]); end
    end
    cycle();
    n_checks++; if (o_busy !== 1'b0 || o_wr_en !== 1'b0 || o_owner !== 2'd0) begin n_fail++; $display("FAIL single_idle: got busy=%b wr_en=%b owner=%0d expected 0/0/0", o_busy, o_wr_en, o_owner); end
    // rr_last is now 0, so requester 1 must beat requester 0.
    load(0, 32'h0B0B_0000, 1'b1);
    load(1, 32'h0C0C_0001, 1'b1);
    cycle();
    cycle();
    n_checks++; if (o_ack !== 4'b0010 || o_data !== 32'h0C0C_0001) begin n_fail++; $display("FAIL single_rr_next: got ack=%b data=%h expected 0010/0c0c0001", o_ack, o_data); end
  endtask

  task automatic test_round_robin();
    int          own;
    logic [3:0]  e_ack;
    logic [31:0] e_data;
    do_reset();
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < NUM_REQ; i++) load(i, 32'hB000 + i*16 + n, 1'b1);
    for (int c = 0; c < 16; c++) begin
      cycle();
      if (c % 2 == 0) begin
        n_checks++; if (o_wr_en !== 1'b0) begin n_fail++; $display("FAIL rr_arb_cycle[%0d]: got wr_en=%b expected 0", c, o_wr_en); end
      end else begin
        own    = (c / 2) % 4;
        e_ack  = 4'(1) << own;
        e_data = 32'hB000 + own*16 + (c / 8);
        n_checks++; if (o_ack !== e_ack || o_owner !== 2'(own)) begin n_fail++; $display("FAIL rr_grant[%0d]: got ack=%b owner=%0d expected %b/%0d", c, o_ack, o_owner, e_ack, own); end
        n_checks++; if (o_data !== e_data) begin n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", c, o_data, e_data); end
      end
    end
  endtask

  task automatic test_burst_cap();
    int          exp_own [$];
    logic [31:0] exp_d [$];
    logic [3:0]  e_ack;
    do_reset();
    for (int b = 0; b < 20; b++) load(2, 32'hC200 + b, 1'b0);
    cycle();
    load(1, 32'hC100, 1'b0);
    load(1, 32'hC101, 1'b1);
    for (int k = 0; k < 8; k++) exp_own.push_back(2);
    exp_own.push_back(-1); exp_own.push_back(1); exp_own.push_back(1); exp_own.push_back(-1);
    for (int k = 0; k < 8; k++) exp_own.push_back(2);
    exp_own.push_back(-1);
    for (int k = 0; k < 4; k++) exp_own.push_back(2);
    for (int k = 0; k < 8; k++) exp_d.push_back(32'hC200 + k);
    exp_d.push_back(32'hC100); exp_d.push_back(32'hC101);
    for (int k = 8; k < 20; k++) exp_d.push_back(32'hC200 + k);
    for (int c = 0; c < exp_own.size(); c++) begin
      cycle();
      if (exp_own[c] < 0) begin
        n_checks++; if (o_wr_en !== 1'b0) begin n_fail++; $display("FAIL cap_arb[%0d]: got wr_en=%b expected 0", c, o_wr_en); end
      end else begin
        e_ack = 4'(1) << exp_own[c];
        n_checks++; if (o_ack !== e_ack) begin n_fail++; $display("FAIL cap_ack[%0d]: got %b expected %b", c, o_ack, e_ack); end
      end
    end
    n_checks++; if (wr_log.size() != exp_d.size()) begin n_fail++; $display("FAIL cap_count: got %0d expected %0d", wr_log.size(), exp_d.size()); end
    for (int k = 0; k < exp_d.size() && k < wr_log.size(); k++) begin
      n_checks++; if (wr_log[k] !== exp_d[k]) begin n_fail++; $display("FAIL cap_order[%0d]: got %h expected %h", k, wr_log[k], exp_d[k]); end
    end
    // Requester 2 ran dry without last: grant is held, nothing written.
    cycle();
    n_checks++; if (o_busy !== 1'b1 || o_wr_en !== 1'b0 || o_owner !== 2'd2) begin n_fail++; $display("FAIL cap_hold: got busy=%b wr_en=%b owner=%0d expected 1/0/2", o_busy, o_wr_en, o_owner); end
  endtask

  task automatic test_backpressure();
    logic [8:0] full_pat;
    logic [8:0] en_pat;
    logic [3:0] e_ack;
    full_pat = 9'b0_0111_1000;
    en_pat   = 9'b1_1000_0110;
    do_reset();
    for (int b = 0; b < 4; b++) load(3, 32'hD000 + b, (b == 3));
    for (int c = 0; c < 9; c++) begin
      wr_full = full_pat[c];
      cycle();
      e_ack = en_pat[c] ? 4'b1000 : 4'b0000;
      n_checks++; if (o_wr_en !== en_pat[c] || o_ack !== e_ack) begin n_fail++; $display("FAIL bp_cycle[%0d]: got wr_en=%b ack=%b expected %b/%b", c, o_wr_en, o_ack, en_pat[c], e_ack); end
      if (!en_pat[c]) begin
        n_checks++; if (o_data !== 32'h0) begin n_fail++; $display("FAIL bp_data_zero[%0d]: got %h expected 0", c, o_data); end
      end
    end
    wr_full = 1'b0;
    n_checks++; if (wr_log.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", wr_log.size()); end
    for (int k = 0; k < 4 && k < wr_log.size(); k++) begin
      n_checks++; if (wr_log[k] !== 32'hD000 + k) begin n_fail++; $display("FAIL bp_order[%0d]: got %h expected %h", k, wr_log[k], 32'hD000 + k); end
    end
    cycle();
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL bp_end: got busy=%b expected 0", o_busy); end
`ifdef FIFO_WR_ARB_STATS_EN
    n_checks++; if (stall_count !== 16'd4) begin n_fail++; $display("FAIL bp_stall_count: got %0d expected 4", stall_count); end
    n_checks++; if (beat_count !== {16'd4, 16'd0, 16'd0, 16'd0}) begin n_fail++; $display("FAIL bp_beat_count: got %h expected 0004000000000000", beat_count); end
`endif
  endtask

  task automatic test_last_collision();
    do_reset();
    load(0, 32'hE000, 1'b0);
    load(0, 32'hE001, 1'b1);
    cycle();
    cycle();
    n_checks++; if (o_wr_en !== 1'b1 || o_data !== 32'hE000) begin n_fail++; $display("FAIL coll_first: got wr_en=%b data=%h expected 1/e000", o_wr_en, o_data); end
    wr_full = 1'b1;
    cycle();
    n_checks++; if (o_wr_en !== 1'b0 || o_busy !== 1'b1) begin n_fail++; $display("FAIL coll_blocked: got wr_en=%b busy=%b expected 0/1", o_wr_en, o_busy); end
    wr_full = 1'b0;
    cycle();
    n_checks++; if (o_busy !== 1'b1 || o_wr_en !== 1'b1 || o_data !== 32'hE001 || o_ack !== 4'b0001) begin n_fail++; $display("FAIL coll_resume: got busy=%b wr_en=%b data=%h ack=%b expected 1/1/e001/0001", o_busy, o_wr_en, o_data, o_ack); end
    cycle();
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL coll_end: got busy=%b expected 0", o_busy); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int b = 0; b < 5; b++) load(0, 32'hF000 + b, (b == 4));
    cycle();
    cycle();
    cycle();
    drive_reqs();
    #2;
    n_checks++; if (wr_en !== 1'b1 || wr_data !== 32'hF002) begin n_fail++; $display("FAIL mid_pre: got wr_en=%b data=%h expected 1/f002", wr_en, wr_data); end
    wr_rst_n = 1'b0;
    #1;
    n_checks++; if (wr_en !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_drop: got wr_en=%b ack=%b busy=%b expected 0/0000/0", wr_en, ack, busy); end
    clear_all();
    for (int i = 0; i < NUM_REQ; i++) load(i, 32'h6000 + i, 1'b1);
    drive_reqs();
    @(posedge wr_clk);
    @(posedge wr_clk);
    #1;
    wr_rst_n = 1'b1;
    cycle();
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rearb: got busy=%b expected 0", o_busy); end
    cycle();
    n_checks++; if (o_ack !== 4'b0001 || o_data !== 32'h6000) begin n_fail++; $display("FAIL mid_first_winner: got ack=%b data=%h expected 0001/00006000", o_ack, o_data); end
  endtask

  initial begin
    wr_rst_n = 1'b0;
    wr_full  = 1'b0;
    req      = '0;
    req_data = '0;
    req_last = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_burst_cap();
    test_backpressure();
    test_last_collision();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
